// File: rtl/line_buf_pkg.sv
// Shared defaults and helpers for the line buffer array.
package line_buf_pkg;

    localparam int unsigned DefNch   = 2;
    localparam int unsigned DefDw    = 8;
    localparam int unsigned DefDepth = 256;

    // Row length is forced into 1..depth so the pointer always wraps inside the memory.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        if (len == 0) begin
            return 1;
        end
        if (len > depth) begin
            return depth;
        end
        return len;
    endfunction

endpackage

// File: rtl/line_buf_array_if.sv
// Data/control bundle for line_buf_array; slave is the buffer, master is the producer.
interface line_buf_array_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 256
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic              clr;
    logic [LW-1:0]     cfg_len;
    logic              in_valid;
    logic [NCH*DW-1:0] in_data;
    logic              out_valid;
    logic [NCH*DW-1:0] out_data;
    logic [AW-1:0]     out_col;
    logic              row_done;

    modport master (
        output clr, cfg_len, in_valid, in_data,
        input  out_valid, out_data, out_col, row_done
    );

    modport slave (
        input  clr, cfg_len, in_valid, in_data,
        output out_valid, out_data, out_col, row_done
    );

endinterface

// File: rtl/line_buf_lane.sv
// One channel of the line buffer: row memory with read-before-write and registered read data.
module line_buf_lane #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Never reset: stale contents are masked by out_valid at the top level.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Non-blocking update means this captures the value from one row ago.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (we) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_buf_array.sv
// Multi-lane line buffer: delays each lane by exactly one row with shared column control.
module line_buf_array
    import line_buf_pkg::*;
#(
    parameter int unsigned NCH   = DefNch,
    parameter int unsigned DW    = DefDw,
    parameter int unsigned DEPTH = DefDepth
) (
    input logic              clk,
    input logic              rst_n,
    line_buf_array_if.slave  bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [AW-1:0] ptr_q, ptr_d;
    logic          filled_q, filled_d;
    logic [LW-1:0] len_q, len_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_col_q, out_col_d;
    logic          row_done_q, row_done_d;
    logic [LW-1:0] len_cfg;
    logic          push;
    logic          last;

    assign len_cfg = LW'(clamp_len(32'(bus.cfg_len), DEPTH));
    assign push    = bus.in_valid & ~bus.clr;
    assign last    = (LW'(ptr_q) == (len_q - LW'(1)));

    always_comb begin
        ptr_d       = ptr_q;
        filled_d    = filled_q;
        len_d       = len_q;
        out_valid_d = 1'b0;
        out_col_d   = out_col_q;
        row_done_d  = 1'b0;
        if (bus.clr) begin
            ptr_d    = '0;
            filled_d = 1'b0;
            len_d    = len_cfg;
        end else if (bus.in_valid) begin
            out_valid_d = filled_q;
            out_col_d   = ptr_q;
            row_done_d  = last;
            filled_d    = filled_q | last;
            ptr_d       = last ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            filled_q    <= 1'b0;
            len_q       <= len_cfg;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            row_done_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            filled_q    <= filled_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_col_q   <= out_col_d;
            row_done_q  <= row_done_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        line_buf_lane #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (push),
            .addr  (ptr_q),
            .wdata (bus.in_data[k*DW +: DW]),
            .rdata (bus.out_data[k*DW +: DW])
        );
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_col   = out_col_q;
    assign bus.row_done  = row_done_q;

endmodule

// File: tb/tb_line_buf_array.sv
// Directed bench for line_buf_array: row delay, lanes, gaps, clamps, clr and reset.
module tb_line_buf_array;

    localparam int unsigned NCH   = 2;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    line_buf_array_if #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) bus ();

    line_buf_array #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic v, input logic c, input logic [7:0] d0, input logic [7:0] d1);
        bus.in_valid = v;
        bus.clr      = c;
        bus.in_data  = {d1, d0};
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] len);
        rst_n       = 1'b0;
        bus.cfg_len = len;
        step(1'b1, 1'b0, 8'h5A, 8'hA5);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(5'd4);
        checks++;
        if ({bus.out_valid, bus.row_done, bus.out_col, bus.out_data} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {bus.out_valid, bus.row_done, bus.out_col, bus.out_data});
        end
    endtask

    task automatic test_basic();
        logic [5:0] exp_ctl;
        do_reset(5'd4);
        for (int n = 1; n <= 12; n++) begin
            step(1'b1, 1'b0, 8'(n), 8'(n + 64));
            exp_ctl = {n > 4, (n % 4) == 0, 4'((n - 1) % 4)};
            checks++;
            if ({bus.out_valid, bus.row_done, bus.out_col} !== exp_ctl) begin
                failures++;
                $display("FAIL basic_ctl push=%0d got=%b exp=%b", n,
                         {bus.out_valid, bus.row_done, bus.out_col}, exp_ctl);
            end
            if (n > 4) begin
                checks++;
                if (bus.out_data !== {8'(n - 4 + 64), 8'(n - 4)}) begin
                    failures++;
                    $display("FAIL basic_data push=%0d got=%h exp=%h", n, bus.out_data,
                             {8'(n - 4 + 64), 8'(n - 4)});
                end
            end
        end
    endtask

    task automatic test_lanes();
        logic [15:0] exp_d;
        do_reset(5'd3);
        for (int n = 1; n <= 9; n++) begin
            step(1'b1, 1'b0, 8'(n), 8'(255 - n));
            checks++;
            if (bus.out_valid !== (n > 3)) begin
                failures++;
                $display("FAIL lanes_valid push=%0d got=%b exp=%b", n, bus.out_valid, n > 3);
            end
            if (n > 3) begin
                exp_d = {8'(255 - (n - 3)), 8'(n - 3)};
                checks++;
                if (bus.out_data !== exp_d) begin
                    failures++;
                    $display("FAIL lanes_data push=%0d got=%h exp=%h", n, bus.out_data, exp_d);
                end
            end
        end
    endtask

    task automatic test_gaps();
        logic [5:0]  exp_ctl;
        logic [15:0] exp_d;
        do_reset(5'd4);
        for (int n = 1; n <= 12; n++) begin
            step(1'b1, 1'b0, 8'(n), 8'(n + 64));
            exp_ctl = {n > 4, (n % 4) == 0, 4'((n - 1) % 4)};
            exp_d   = {8'(n - 4 + 64), 8'(n - 4)};
            checks++;
            if ({bus.out_valid, bus.row_done, bus.out_col} !== exp_ctl) begin
                failures++;
                $display("FAIL gaps_ctl push=%0d got=%b exp=%b", n,
                         {bus.out_valid, bus.row_done, bus.out_col}, exp_ctl);
            end
            if (n > 4) begin
                checks++;
                if (bus.out_data !== exp_d) begin
                    failures++;
                    $display("FAIL gaps_data push=%0d got=%h exp=%h", n, bus.out_data, exp_d);
                end
            end
            for (int g = 0; g < n % 3; g++) begin
                step(1'b0, 1'b0, 8'hEE, 8'hEE);
                checks++;
                if ({bus.out_valid, bus.row_done, bus.out_col} !== {2'b00, exp_ctl[3:0]}) begin
                    failures++;
                    $display("FAIL gaps_idle_ctl push=%0d got=%b exp=%b", n,
                             {bus.out_valid, bus.row_done, bus.out_col}, {2'b00, exp_ctl[3:0]});
                end
                if (n > 4) begin
                    checks++;
                    if (bus.out_data !== exp_d) begin
                        failures++;
                        $display("FAIL gaps_idle_data push=%0d got=%h exp=%h", n,
                                 bus.out_data, exp_d);
                    end
                end
            end
        end
    endtask

    task automatic test_clamp();
        logic [5:0] exp_ctl;
        do_reset(5'd0);
        for (int n = 1; n <= 4; n++) begin
            step(1'b1, 1'b0, 8'(16 + n), 8'(32 + n));
            exp_ctl = {n > 1, 1'b1, 4'd0};
            checks++;
            if ({bus.out_valid, bus.row_done, bus.out_col} !== exp_ctl) begin
                failures++;
                $display("FAIL clamp0_ctl push=%0d got=%b exp=%b", n,
                         {bus.out_valid, bus.row_done, bus.out_col}, exp_ctl);
            end
            if (n > 1) begin
                checks++;
                if (bus.out_data !== {8'(32 + n - 1), 8'(16 + n - 1)}) begin
                    failures++;
                    $display("FAIL clamp0_data push=%0d got=%h exp=%h", n, bus.out_data,
                             {8'(32 + n - 1), 8'(16 + n - 1)});
                end
            end
        end
        do_reset(5'(DEPTH + 5));
        for (int n = 1; n <= DEPTH + 2; n++) begin
            step(1'b1, 1'b0, 8'(n), 8'(n + 100));
            exp_ctl = {n > DEPTH, n == DEPTH, 4'((n - 1) % DEPTH)};
            checks++;
            if ({bus.out_valid, bus.row_done, bus.out_col} !== exp_ctl) begin
                failures++;
                $display("FAIL clampmax_ctl push=%0d got=%b exp=%b", n,
                         {bus.out_valid, bus.row_done, bus.out_col}, exp_ctl);
            end
            if (n > DEPTH) begin
                checks++;
                if (bus.out_data !== {8'(n - DEPTH + 100), 8'(n - DEPTH)}) begin
                    failures++;
                    $display("FAIL clampmax_data push=%0d got=%h exp=%h", n, bus.out_data,
                             {8'(n - DEPTH + 100), 8'(n - DEPTH)});
                end
            end
        end
    endtask

    task automatic test_clr();
        logic [5:0] exp_ctl;
        do_reset(5'd4);
        for (int n = 1; n <= 6; n++) begin
            step(1'b1, 1'b0, 8'(n), 8'(n + 64));
        end
        bus.cfg_len = 5'd2;
        // Length must stay 4 until clr.
        for (int n = 7; n <= 10; n++) begin
            step(1'b1, 1'b0, 8'(n), 8'(n + 64));
            exp_ctl = {1'b1, (n % 4) == 0, 4'((n - 1) % 4)};
            checks++;
            if ({bus.out_valid, bus.row_done, bus.out_col} !== exp_ctl) begin
                failures++;
                $display("FAIL lenhold_ctl push=%0d got=%b exp=%b", n,
                         {bus.out_valid, bus.row_done, bus.out_col}, exp_ctl);
            end
            checks++;
            if (bus.out_data !== {8'(n - 4 + 64), 8'(n - 4)}) begin
                failures++;
                $display("FAIL lenhold_data push=%0d got=%h exp=%h", n, bus.out_data,
                         {8'(n - 4 + 64), 8'(n - 4)});
            end
        end
        step(1'b1, 1'b1, 8'hAA, 8'hAA);
        checks++;
        if ({bus.out_valid, bus.row_done} !== 2'b00) begin
            failures++;
            $display("FAIL clr_flags got=%b exp=00", {bus.out_valid, bus.row_done});
        end
        for (int n = 11; n <= 13; n++) begin
            step(1'b1, 1'b0, 8'(n), 8'(n + 64));
            exp_ctl = {n == 13, n == 12, 4'((n - 11) % 2)};
            checks++;
            if ({bus.out_valid, bus.row_done, bus.out_col} !== exp_ctl) begin
                failures++;
                $display("FAIL clr_ctl push=%0d got=%b exp=%b", n,
                         {bus.out_valid, bus.row_done, bus.out_col}, exp_ctl);
            end
        end
        checks++;
        if (bus.out_data !== {8'(11 + 64), 8'd11}) begin
            failures++;
            $display("FAIL clr_data got=%h exp=%h", bus.out_data, {8'(11 + 64), 8'd11});
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] exp_ctl;
        do_reset(5'd4);
        for (int n = 1; n <= 6; n++) begin
            step(1'b1, 1'b0, 8'(n), 8'(n + 64));
        end
        rst_n = 1'b0;
        step(1'b0, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b1;
        checks++;
        if ({bus.out_valid, bus.row_done, bus.out_col, bus.out_data} !== 22'd0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h exp=0",
                     {bus.out_valid, bus.row_done, bus.out_col, bus.out_data});
        end
        for (int n = 7; n <= 11; n++) begin
            step(1'b1, 1'b0, 8'(n), 8'(n + 64));
            exp_ctl = {n == 11, n == 10, 4'((n - 7) % 4)};
            checks++;
            if ({bus.out_valid, bus.row_done, bus.out_col} !== exp_ctl) begin
                failures++;
                $display("FAIL midrst_ctl push=%0d got=%b exp=%b", n,
                         {bus.out_valid, bus.row_done, bus.out_col}, exp_ctl);
            end
        end
        checks++;
        if (bus.out_data !== {8'(7 + 64), 8'd7}) begin
            failures++;
            $display("FAIL midrst_data got=%h exp=%h", bus.out_data, {8'(7 + 64), 8'd7});
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.clr      = 1'b0;
        bus.cfg_len  = 5'd4;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_basic();
        test_lanes();
        test_gaps();
        test_clamp();
        test_clr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
